// File: rtl/ro_freq_meter_pkg.sv
// Shared constants for the ring-oscillator frequency meter: FSM encoding and default sizing.
package ro_meter_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int WIN_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_CYC_DEF  = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SETTLE  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/ro_freq_meter_if.sv
// Request/result bundle of the frequency meter; master starts measurements, slave reports counts.
interface ro_freq_meter_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             start;
    logic [WIN_W-1:0] win_len;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             count_valid;
    logic             overflow;

    modport master (
        output start, win_len,
        input  busy, done, count, count_valid, overflow
    );

    modport slave (
        input  start, win_len,
        output busy, done, count, count_valid, overflow
    );
endinterface

// File: rtl/ro_freq_meter_sync_edge_det.sv
// Synchronizes the asynchronous oscillator tap and flags rising edges of the synchronized level.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Free-running so prev already tracks the tap before any window opens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the ring, settles, counts tap edges over win_len cycles.
module ro_freq_meter
    import ro_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int WIN_W       = WIN_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ro_freq_meter_if.slave         bus,
    input  logic                   ro_in,
    output logic                   ro_en
);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    logic [1:0]       state;
    logic [SET_W-1:0] settle_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic [WIN_W-1:0] win_len_q;
    logic [CNT_W-1:0] edge_cnt;
    logic             ovf_acc;
    logic [CNT_W-1:0] count_q;
    logic             count_valid_q;
    logic             overflow_q;

    logic             rise;
    logic             edge_inc;
    logic             edge_sat;
    logic [CNT_W-1:0] edge_cnt_nxt;
    logic             ovf_nxt;
    logic             enter_done;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (ro_in),
        .rise (rise)
    );

    // Next edge count includes the edge of the current cycle, so the last window cycle is counted.
    always_comb begin
        edge_inc     = (state == ST_MEASURE) && rise;
        edge_sat     = (edge_cnt == '1);
        edge_cnt_nxt = edge_cnt;
        ovf_nxt      = ovf_acc;
        if (edge_inc) begin
            if (edge_sat) ovf_nxt      = 1'b1;
            else          edge_cnt_nxt = edge_cnt + CNT_W'(1);
        end
        enter_done = ((state == ST_SETTLE) && (settle_cnt == '0) && (win_len_q == '0)) ||
                     ((state == ST_MEASURE) && (win_cnt == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            settle_cnt    <= '0;
            win_cnt       <= '0;
            win_len_q     <= '0;
            edge_cnt      <= '0;
            ovf_acc       <= 1'b0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        win_len_q     <= bus.win_len;
                        edge_cnt      <= '0;
                        ovf_acc       <= 1'b0;
                        count_valid_q <= 1'b0;
                        overflow_q    <= 1'b0;
                        settle_cnt    <= SET_W'(SETTLE_CYC - 1);
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == '0) begin
                        win_cnt <= win_len_q - WIN_W'(1);
                        state   <= (win_len_q == '0) ? ST_DONE : ST_MEASURE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                ST_MEASURE: begin
                    edge_cnt <= edge_cnt_nxt;
                    ovf_acc  <= ovf_nxt;
                    if (win_cnt == '0) state   <= ST_DONE;
                    else               win_cnt <= win_cnt - WIN_W'(1);
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase

            // Result registers load on entry to DONE so they are already valid alongside done.
            if (enter_done) begin
                count_q       <= edge_cnt_nxt;
                overflow_q    <= ovf_nxt;
                count_valid_q <= 1'b1;
            end
        end
    end

    assign ro_en           = (state == ST_SETTLE) || (state == ST_MEASURE);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.done        = (state == ST_DONE);
    assign bus.count       = count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_ro_freq_meter.sv
// Directed and randomized bench for ro_freq_meter against a cycle-indexed tap history model.
module tb_ro_freq_meter;
    import ro_meter_pkg::*;

    localparam int S    = SETTLE_CYC_DEF;
    localparam int SYNC = 2;
    localparam int HMAX = 20000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ro_in = 1'b0;
    logic ro_en, ro_en4;

    ro_freq_meter_if #(.CNT_W(16), .WIN_W(16)) bus ();
    ro_freq_meter_if #(.CNT_W(4),  .WIN_W(16)) bus4 ();

    ro_freq_meter #(.CNT_W(16), .WIN_W(16), .SYNC_STAGES(SYNC), .SETTLE_CYC(S)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .ro_in(ro_in), .ro_en(ro_en)
    );
    ro_freq_meter #(.CNT_W(4), .WIN_W(16), .SYNC_STAGES(SYNC), .SETTLE_CYC(S)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4), .ro_in(ro_in), .ro_en(ro_en4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tap generator: 0 = constant level, 1 = square wave of half-period 'half', 2 = random holds >= 2 cycles
    bit hist [0:HMAX-1];
    int mode = 0;
    bit level = 1'b0;
    int half = 4;
    int hold = 0;

    always @(negedge clk) begin
        logic v;
        v = ro_in;
        case (mode)
            0: v = level;
            1: if (hold <= 1) begin v = ~ro_in; hold = half; end else hold = hold - 1;
            default: if (hold <= 1) begin v = ~ro_in; hold = int'($urandom_range(2, 6)); end
                     else hold = hold - 1;
        endcase
        ro_in = v;
        if (cyc < HMAX) hist[cyc] = v;
    end

    int checks = 0;
    int failures = 0;
    int last_cnt;
    int last_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rising edges of the tap seen SYNC cycles late, counted over the window cycles c0+1+S .. c0+S+w
    function automatic int model_edges(input int c0, input int w);
        int n = 0;
        for (int m = c0 + 1 + S; m <= c0 + S + w; m++)
            if (hist[m-SYNC] && !hist[m-SYNC-1]) n++;
        return n;
    endfunction

    task automatic measure(input bit sel4, input int w, input string tag, input bit repulse);
        int c0, dcyc, n, maxv;
        bit got_done;
        logic [31:0] cnt;
        got_done = 1'b0;
        dcyc = 0;
        @(negedge clk);
        if (sel4) begin bus4.start = 1'b1; bus4.win_len = 16'(w); end
        else      begin bus.start  = 1'b1; bus.win_len  = 16'(w); end
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        bus4.start = 1'b0;
        chk({tag, "_busy"},  32'(sel4 ? bus4.busy : bus.busy), 32'd1);
        chk({tag, "_ro_en"}, 32'(sel4 ? ro_en4 : ro_en), 32'd1);
        chk({tag, "_cv_clr"}, 32'(sel4 ? bus4.count_valid : bus.count_valid), 32'd0);
        for (int i = 0; i < S + w + 10 && !got_done; i++) begin
            @(negedge clk);
            if (sel4 ? bus4.done : bus.done) begin got_done = 1'b1; dcyc = cyc; end
            if (repulse && i == 2) begin bus.start = 1'b1; bus.win_len = 16'(w + 37); end
            if (repulse && i == 3) bus.start = 1'b0;
        end
        chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
        if (got_done) begin
            n = model_edges(c0, w);
            maxv = sel4 ? 15 : 65535;
            cnt = sel4 ? 32'(bus4.count) : 32'(bus.count);
            last_cnt = int'(cnt);
            last_ovf = int'(sel4 ? bus4.overflow : bus.overflow);
            chk({tag, "_done_cyc"}, 32'(dcyc - c0), 32'(S + w + 1));
            chk({tag, "_count"}, cnt, 32'(n > maxv ? maxv : n));
            chk({tag, "_ovf"}, 32'(last_ovf), 32'(n > maxv));
            chk({tag, "_cv"}, 32'(sel4 ? bus4.count_valid : bus.count_valid), 32'd1);
            @(negedge clk);
            chk({tag, "_done_pulse"}, 32'(sel4 ? bus4.done : bus.done), 32'd0);
            chk({tag, "_idle"}, 32'(sel4 ? (bus4.busy | ro_en4) : (bus.busy | ro_en)), 32'd0);
            chk({tag, "_hold"}, sel4 ? 32'(bus4.count) : 32'(bus.count), cnt);
        end
    endtask

    initial begin
        int extra_done;
        bus.start = 1'b0;  bus.win_len = '0;
        bus4.start = 1'b0; bus4.win_len = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {26'd0, bus.busy, bus.done, ro_en, bus.count_valid, bus.overflow,
                         |bus.count}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // T2: clk/8 tap over 800 cycles
        mode = 1; half = 4;
        repeat (10) @(negedge clk);
        measure(1'b0, 800, "t2", 1'b0);
        chk("t2_range", 32'(last_cnt >= 99 && last_cnt <= 101), 32'd1);

        // T1: asynchronous abort mid-window
        @(negedge clk); bus.start = 1'b1; bus.win_len = 16'd100;
        @(negedge clk); bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_abort", {28'd0, ro_en, bus.busy, bus.count_valid, |bus.count}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        measure(1'b0, 40, "t1_after", 1'b0);

        // T3: tap high before start must not yield a false edge
        mode = 0; level = 1'b1;
        repeat (10) @(negedge clk);
        measure(1'b0, 50, "t3", 1'b0);
        chk("t3_zero", 32'(last_cnt), 32'd0);

        // T5: zero-length window
        measure(1'b0, 0, "t5", 1'b0);

        // T4: 4-bit counter saturates
        mode = 1; half = 2;
        repeat (5) @(negedge clk);
        measure(1'b1, 200, "t4", 1'b0);
        chk("t4_sat", 32'(last_cnt), 32'd15);
        chk("t4_ovf_set", 32'(last_ovf), 32'd1);

        // T6: start and win_len changes while busy are ignored
        mode = 2;
        measure(1'b0, 60, "t6", 1'b1);
        extra_done = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (bus.done) extra_done++;
        end
        chk("t6_single_done", 32'(extra_done), 32'd0);
        measure(1'b0, 30, "t6_next", 1'b0);

        for (int k = 0; k < 6; k++) measure(1'b0, int'($urandom_range(1, 300)), "rnd", 1'b0);
        for (int k = 0; k < 4; k++) measure(1'b1, int'($urandom_range(20, 200)), "rnd4", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
